// File: rtl/frame_scheduler.sv
// Per-frame sequencer: on each vsync falling edge runs physics, collision and optional scroll stages,
// each with a watchdog, and manages the game-over / restart handshake.
module frame_scheduler #(
  parameter int TIMEOUT     = 1024,
  parameter int SCROLL_LINE = 200,
  parameter int DEATH_LINE  = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  input  logic [9:0] doodle_y,
  input  logic       restart_req,
  input  logic       phys_done,
  input  logic       coll_done,
  input  logic       scroll_done,
  output logic       phys_go,
  output logic       coll_go,
  output logic       scroll_go,
  output logic       busy,
  output logic       game_over,
  output logic       restart,
  output logic       timeout_flag,
  output logic [7:0] overrun_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_PHYS, S_COLL, S_SCROLL, S_OVER} state_t;

  localparam int              TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          sync_q, rreq_q;
  logic          phys_go_q, coll_go_q, scroll_go_q;
  logic          busy_q, game_over_q, restart_q, timeout_flag_q;
  logic [7:0]    overrun_cnt_q;

  logic          frame_start, restart_edge, in_stage;
  logic          done_sel, stage_done, stage_abort, stage_exit;
  logic [31:0]   y_ext;

  always_comb begin
    frame_start  = sync_q & ~frame_sync;
    restart_edge = restart_req & ~rreq_q;
    in_stage     = (state_q == S_PHYS) || (state_q == S_COLL) || (state_q == S_SCROLL);
    y_ext        = {22'd0, doodle_y};

    case (state_q)
      S_PHYS:   done_sel = phys_done;
      S_COLL:   done_sel = coll_done;
      S_SCROLL: done_sel = scroll_done;
      default:  done_sel = 1'b0;
    endcase

    // A done strobe coincident with the go pulse belongs to a previous request, so ignore it.
    stage_done  = in_stage & (timer_q != '0) & done_sel;
    stage_abort = in_stage & ~stage_done & (timer_q == TLAST);
    stage_exit  = stage_done | stage_abort;

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = S_PHYS;
      S_PHYS:   if (stage_exit)  state_d = S_COLL;
      S_COLL: begin
        if (stage_exit) begin
          if (y_ext >= $unsigned(DEATH_LINE))      state_d = S_OVER;
          else if (y_ext < $unsigned(SCROLL_LINE)) state_d = S_SCROLL;
          else                                     state_d = S_IDLE;
        end
      end
      S_SCROLL: if (stage_exit)   state_d = S_IDLE;
      S_OVER:   if (restart_edge) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      sync_q         <= 1'b1;
      rreq_q         <= 1'b1;
      phys_go_q      <= 1'b0;
      coll_go_q      <= 1'b0;
      scroll_go_q    <= 1'b0;
      busy_q         <= 1'b0;
      game_over_q    <= 1'b0;
      restart_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
      overrun_cnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= frame_sync;
      rreq_q  <= restart_req;

      if (state_d != state_q)  timer_q <= '0;
      else if (in_stage)       timer_q <= timer_q + TW'(1);

      // Outputs are decoded from the next state so they line up with the state register.
      phys_go_q   <= (state_d == S_PHYS)   && (state_q != S_PHYS);
      coll_go_q   <= (state_d == S_COLL)   && (state_q != S_COLL);
      scroll_go_q <= (state_d == S_SCROLL) && (state_q != S_SCROLL);
      busy_q      <= (state_d == S_PHYS) || (state_d == S_COLL) || (state_d == S_SCROLL);
      game_over_q <= (state_d == S_OVER);
      restart_q   <= (state_q == S_OVER) && restart_edge;

      if ((state_q == S_OVER) && restart_edge) begin
        timeout_flag_q <= 1'b0;
        overrun_cnt_q  <= 8'd0;
      end else begin
        if (stage_abort) timeout_flag_q <= 1'b1;
        if (frame_start && in_stage && (overrun_cnt_q != 8'hFF))
          overrun_cnt_q <= overrun_cnt_q + 8'd1;
      end
    end
  end

  assign phys_go      = phys_go_q;
  assign coll_go      = coll_go_q;
  assign scroll_go    = scroll_go_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;
  assign restart      = restart_q;
  assign timeout_flag = timeout_flag_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 1024, max cycles a stage waits for its done before it is aborted.
REQ-002 Parameter SCROLL_LINE, default 200, doodle_y strictly below this line requests a platform scroll.
REQ-003 Parameter DEATH_LINE, default 480, doodle_y at or beyond this line ends the game.
REQ-004 clk  in  1  single system clock (pixel clock domain); all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 frame_sync  in  1  vertical sync from beam establisher, active-low; falling edge marks frame start.
REQ-007 doodle_y  in  10  current doodle vertical position, unsigned.
REQ-008 restart_req  in  1  restart button level, active-high, synchronous to clk.
REQ-009 phys_done, coll_done, scroll_done  in  1 each  completion strobes from doodle, collision observer, platforms mover.
REQ-010 phys_go, coll_go, scroll_go  out  1 each  one-cycle start pulses to those units.
REQ-011 busy  out  1  high whenever state is PHYS, COLL or SCROLL.
REQ-012 game_over  out  1  high while state is OVER.
REQ-013 restart  out  1  one-cycle pulse resetting game units.
REQ-014 timeout_flag  out  1  sticky; set on any stage abort.
REQ-015 overrun_cnt  out  8  saturating count of dropped frame starts.

Function
REQ-016 frame_sync SHALL be registered once; frame_start = previous high and current low (one cycle).
REQ-017 States SHALL be IDLE, PHYS, COLL, SCROLL, OVER; state, outputs and counters registered.
REQ-018 IDLE + frame_start -> PHYS next cycle; frame_start in OVER SHALL be ignored without counting.
REQ-019 Each go SHALL be high exactly on the first cycle in its stage state, low otherwise.
REQ-020 Stage timer SHALL clear on stage entry, increment each cycle; done sampled only from second cycle in stage.
REQ-021 Stage done seen -> leave on next edge; done outside its own stage (or on go cycle) SHALL be ignored.
REQ-022 Timer reaching TIMEOUT-1 without done SHALL abort stage, set timeout_flag, take normal exit path.
REQ-023 PHYS exit -> COLL.
REQ-024 COLL exit: doodle_y >= DEATH_LINE -> OVER; else doodle_y < SCROLL_LINE -> SCROLL; else IDLE; death wins.
REQ-025 SCROLL exit -> IDLE.
REQ-026 frame_start while busy SHALL NOT restart sequence; overrun_cnt +1, saturates at 255.
REQ-027 Frame_start on the same cycle a stage exits to IDLE counts as overrun; the frame is not started.
REQ-028 OVER: registered restart_req rising edge -> restart pulse one cycle, state IDLE, timeout_flag and overrun_cnt cleared same edge.
REQ-029 restart_req held high through entry to OVER SHALL NOT restart until released and pressed again.
REQ-030 doodle_y sampled only in the COLL exit cycle.

Reset
REQ-031 rst low SHALL immediately force IDLE, all go/restart low, busy 0, game_over 0, timeout_flag 0, overrun_cnt 0, timer 0, sync register high, restart edge register high.
REQ-032 Reset mid-stage SHALL abandon sequence; first frame_start after release starts fresh PHYS.

Verification
REQ-033 frame_sync 1->0 in IDLE, doodle_y=300, each done 3 cycles after go -> phys_go, coll_go pulses, no scroll_go, IDLE; busy 8 cycles.
REQ-034 doodle_y=150 at COLL exit -> scroll_go pulse, IDLE after scroll_done; doodle_y=480 -> game_over=1, no scroll_go.
REQ-035 TIMEOUT=16, phys_done never -> coll_go at 16 cycles after phys_go, timeout_flag=1 stays set.
REQ-036 second frame_start during COLL, repeated 300 times -> overrun_cnt 255, no extra phys_go.
REQ-037 OVER with restart_req high on entry -> no restart; release then press -> one restart pulse, IDLE, flags cleared.
REQ-038 rst low during SCROLL -> all outputs at reset values same cycle; post-release frame_start -> phys_go.
